// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: aluop codes,
// register/bus constants, FSM state encoding and lane/alignment helpers.
package mem_lsu_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
    localparam logic [31:0] ZERO_WORD    = 32'd0;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_aligned(input logic [7:0] op, input logic [1:0] off);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return ~off[0];
            EXE_LW_OP, EXE_SW_OP:             return (off == 2'b00);
            default:                          return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b0001 << off;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return off[1] ? 4'b1100 : 4'b0011;
            default:                          return 4'b1111;
        endcase
    endfunction

    // Store data is replicated across lanes so the bus slave only honours sel.
    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] reg2);
        case (op)
            EXE_SB_OP: return {4{reg2[7:0]}};
            EXE_SH_OP: return {2{reg2[15:0]}};
            default:   return reg2;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half from a bus word
// and sign- or zero-extends it according to the load opcode.
module mem_lsu_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [7:0]  aluop,
    output logic [31:0] result
);
    import mem_lsu_pkg::*;

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{byte_off, 3'b000} +: 8];
        half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (aluop)
            EXE_LB_OP:  result = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: result = {24'd0, byte_v};
            EXE_LH_OP:  result = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: result = {16'd0, half_v};
            default:    result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one bus transaction per memory op,
// stalls the pipeline while it is outstanding, and formats load results.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        mem_aluop,
    input  logic [ADDR_W-1:0] mem_mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stallreq_mem,
    output logic              misalign,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_sel,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_ack,
    input  logic [DATA_W-1:0] dbus_rdata
);
    import mem_lsu_pkg::*;

    mem_state_e        state_q, state_d;
    logic              dbus_req_q, dbus_req_d;
    logic              dbus_we_q, dbus_we_d;
    logic [ADDR_W-1:0] dbus_addr_q, dbus_addr_d;
    logic [3:0]        dbus_sel_q, dbus_sel_d;
    logic [DATA_W-1:0] dbus_wdata_q, dbus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              mem_op;
    logic              aligned;
    logic [DATA_W-1:0] load_result;

    assign mem_op  = is_mem_op(mem_aluop);
    assign aligned = is_aligned(mem_aluop, mem_mem_addr[1:0]);

    mem_lsu_load_align u_load_align (
        .rdata    (rdata_q),
        .byte_off (mem_mem_addr[1:0]),
        .aluop    (mem_aluop),
        .result   (load_result)
    );

    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_sel_d   = dbus_sel_q;
        dbus_wdata_d = dbus_wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            MEM_IDLE: begin
                if (mem_op && aligned) begin
                    state_d      = MEM_BUSY;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = is_store(mem_aluop);
                    dbus_addr_d  = {mem_mem_addr[ADDR_W-1:2], 2'b00};
                    dbus_sel_d   = lane_sel(mem_aluop, mem_mem_addr[1:0]);
                    dbus_wdata_d = store_data(mem_aluop, mem_reg2);
                end
            end
            MEM_BUSY: begin
                // An ack only counts while the request is actually on the bus.
                if (dbus_ack && dbus_req_q) begin
                    state_d    = MEM_DONE;
                    dbus_req_d = 1'b0;
                    rdata_d    = dbus_rdata;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MEM_IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_sel_q   <= 4'b0000;
            dbus_wdata_q <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_sel_q   <= dbus_sel_d;
            dbus_wdata_q <= dbus_wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        stallreq_mem = 1'b0;
        misalign     = 1'b0;
        if (rst) begin
            wb_wd    = NOP_REG_ADDR;
            wb_wreg  = 1'b0;
            wb_wdata = ZERO_WORD;
        end else begin
            case (state_q)
                MEM_IDLE: begin
                    if (mem_op) begin
                        wb_wreg      = 1'b0;
                        stallreq_mem = aligned;
                        misalign     = ~aligned;
                    end
                end
                MEM_BUSY: begin
                    wb_wreg      = 1'b0;
                    stallreq_mem = 1'b1;
                end
                default: begin
                    if (is_store(mem_aluop))
                        wb_wreg = 1'b0;
                    else if (mem_op)
                        wb_wdata = load_result;
                end
            endcase
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_sel   = dbus_sel_q;
    assign dbus_wdata = dbus_wdata_q;

endmodule
